ex_operand_stage: RTL and testbench

Decode-to-execute pipeline stage that sits directly upstream of the 32-bit ALU. It accepts decoded instructions over a valid/ready handshake and selects register or immediate operands, applying optional writeback forwarding. It steers operands into the ALU's bus_A/bus_B ordering per function code and holds them in a 2-entry skid buffer. Its outputs drive the ALU inputs and the destination-register tag carried toward writeback.

---
 rtl/ex_operand_stage.sv | 178 +++++++++++++++++
 tb/tb_ex_operand_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - Decode-to-execute operand stage with 2-entry skid buffer (optional forwarding: FWD_EN)
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int FUNC_WIDTH     = 5,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic                      in_use_imm,
  input  logic [FUNC_WIDTH-1:0]     in_alu_ctrl,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_rd_we,
  input  logic                      flush,
  input  logic                      fwd_we,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  input  logic [DATA_WIDTH-1:0]     fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_bus_A,
  output logic [DATA_WIDTH-1:0]     out_bus_B,
  output logic [FUNC_WIDTH-1:0]     out_alu_ctrl,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_rd_we
);

  // Occupancy: EMPTY (nothing held), ONE (main only), FULL (main + skid)
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam logic [FUNC_WIDTH-1:0] FN_SUBU = FUNC_WIDTH'(5'b00001);
  localparam logic [FUNC_WIDTH-1:0] FN_SUB  = FUNC_WIDTH'(5'b10001);
  localparam logic [FUNC_WIDTH-1:0] FN_SLL  = FUNC_WIDTH'(5'b00110);
  localparam logic [FUNC_WIDTH-1:0] FN_SRL  = FUNC_WIDTH'(5'b00111);
  localparam logic [FUNC_WIDTH-1:0] FN_SRA  = FUNC_WIDTH'(5'b01000);

  logic [1:0]                state;
  logic                      accept;

  logic [DATA_WIDTH-1:0]     rs1_val;
  logic [DATA_WIDTH-1:0]     rs2_val;
  logic [DATA_WIDTH-1:0]     src2;
  logic [DATA_WIDTH-1:0]     shamt;
  logic [DATA_WIDTH-1:0]     new_a;
  logic [DATA_WIDTH-1:0]     new_b;

  logic [DATA_WIDTH-1:0]     main_a, main_b, skid_a, skid_b;
  logic [FUNC_WIDTH-1:0]     main_ctrl, skid_ctrl;
  logic [REG_ADDR_WIDTH-1:0] main_rd, skid_rd;
  logic                      main_we, skid_we;

  logic                      load_main_new;
  logic                      load_main_skid;
  logic                      load_skid;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready & ~flush;

`ifdef FWD_EN
  // Writeback bypass; register 0 is hardwired and never forwarded
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
    if (fwd_we && (fwd_addr != '0) && (fwd_addr == in_rs1_addr)) rs1_val = fwd_data;
    if (fwd_we && (fwd_addr != '0) && (fwd_addr == in_rs2_addr)) rs2_val = fwd_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_we, fwd_addr, fwd_data, in_rs1_addr, in_rs2_addr};
  assign rs1_val    = in_rs1_data;
  assign rs2_val    = in_rs2_data;
`endif

  assign src2  = in_use_imm ? in_imm : rs2_val;
  assign shamt = {{(DATA_WIDTH-5){1'b0}}, src2[4:0]};

  // Steer operands into the ALU's bus_A/bus_B ordering for the incoming code
  always_comb begin
    new_a = rs1_val;
    new_b = src2;
    case (in_alu_ctrl)
      FN_SUBU, FN_SUB: begin
        new_a = src2;
        new_b = rs1_val;
      end
      FN_SLL, FN_SRL: begin
        new_a = shamt;
        new_b = rs1_val;
      end
      FN_SRA: begin
        new_a = rs1_val;
        new_b = shamt;
      end
      default: begin
        new_a = rs1_val;
        new_b = src2;
      end
    endcase
  end

  assign load_main_new  = accept & ((state == ST_EMPTY) | ((state == ST_ONE) & out_ready));
  assign load_main_skid = (state == ST_FULL) & out_ready;
  assign load_skid      = accept & (state == ST_ONE) & ~out_ready;

  // Occupancy tracking; flush wins over every other transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_ONE;
        ST_ONE: begin
          if (accept && !out_ready)      state <= ST_FULL;
          else if (!accept && out_ready) state <= ST_EMPTY;
        end
        ST_FULL:  if (out_ready) state <= ST_ONE;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Main entry: loaded from the input or promoted from skid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_a    <= '0;
      main_b    <= '0;
      main_ctrl <= '0;
      main_rd   <= '0;
      main_we   <= 1'b0;
    end else if (load_main_new) begin
      main_a    <= new_a;
      main_b    <= new_b;
      main_ctrl <= in_alu_ctrl;
      main_rd   <= in_rd_addr;
      main_we   <= in_rd_we;
    end else if (load_main_skid) begin
      main_a    <= skid_a;
      main_b    <= skid_b;
      main_ctrl <= skid_ctrl;
      main_rd   <= skid_rd;
      main_we   <= skid_we;
    end
  end

  // Skid entry: catches an accepted instruction while main is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_a    <= '0;
      skid_b    <= '0;
      skid_ctrl <= '0;
      skid_rd   <= '0;
      skid_we   <= 1'b0;
    end else if (load_skid) begin
      skid_a    <= new_a;
      skid_b    <= new_b;
      skid_ctrl <= in_alu_ctrl;
      skid_rd   <= in_rd_addr;
      skid_we   <= in_rd_we;
    end
  end

  assign out_bus_A    = main_a;
  assign out_bus_B    = main_b;
  assign out_alu_ctrl = main_ctrl;
  assign out_rd_addr  = main_rd;
  assign out_rd_we    = main_we;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - Self-checking bench for ex_operand_stage (honours FWD_EN)
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic [4:0]  in_alu_ctrl = '0;
  logic [4:0]  in_rd_addr = '0;
  logic        in_rd_we = 1'b0;
  logic        flush = 1'b0;
  logic        fwd_we = 1'b0;
  logic [4:0]  fwd_addr = '0;
  logic [31:0] fwd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_bus_A, out_bus_B;
  logic [4:0]  out_alu_ctrl;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_ctrl(in_alu_ctrl),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .flush(flush),
    .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bus_A(out_bus_A), .out_bus_B(out_bus_B), .out_alu_ctrl(out_alu_ctrl),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  c;
    logic [4:0]  rd;
    logic        we;
  } item_t;

  item_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_value(input logic [4:0] addr, input logic [31:0] data);
    logic hit;
    hit = 1'b0;
`ifdef FWD_EN
    hit = fwd_we && (fwd_addr != 5'd0) && (fwd_addr == addr);
`endif
    return hit ? fwd_data : data;
  endfunction

  // Expected ALU-side instruction for the current input set
  function automatic item_t expected_item();
    item_t it;
    logic [31:0] s1, s2, sh;
    s1 = reg_value(in_rs1_addr, in_rs1_data);
    s2 = in_use_imm ? in_imm : reg_value(in_rs2_addr, in_rs2_data);
    sh = s2 % 32;
    if (in_alu_ctrl == 5'd1 || in_alu_ctrl == 5'd17) begin
      it.a = s2; it.b = s1;
    end else if (in_alu_ctrl == 5'd6 || in_alu_ctrl == 5'd7) begin
      it.a = sh; it.b = s1;
    end else if (in_alu_ctrl == 5'd8) begin
      it.a = s1; it.b = sh;
    end else begin
      it.a = s1; it.b = s2;
    end
    it.c  = in_alu_ctrl;
    it.rd = in_rd_addr;
    it.we = in_rd_we;
    return it;
  endfunction

  // Reference queue: at most two held, head is what the outputs show
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit consumed, accepted;
      item_t nw;
      consumed = (q.size() > 0) && out_ready;
      accepted = in_valid && (q.size() < 2) && !flush;
      nw = expected_item();
      if (flush) begin
        q.delete();
      end else begin
        if (consumed) void'(q.pop_front());
        if (accepted) q.push_back(nw);
      end
    end
  end

  // Compare outputs against the reference every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      check("cmp_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      if (q.size() != 0 && out_valid) begin
        check("cmp_bus_A", out_bus_A, q[0].a);
        check("cmp_bus_B", out_bus_B, q[0].b);
        check("cmp_ctrl", {27'd0, out_alu_ctrl}, {27'd0, q[0].c});
        check("cmp_rd", {27'd0, out_rd_addr}, {27'd0, q[0].rd});
        check("cmp_rd_we", {31'd0, out_rd_we}, {31'd0, q[0].we});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] r1a, input logic [31:0] r1d,
                     input logic [4:0] r2a, input logic [31:0] r2d,
                     input logic [31:0] imm, input logic ui,
                     input logic [4:0] c, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_rs1_addr = r1a;
    in_rs1_data = r1d;
    in_rs2_addr = r2a;
    in_rs2_data = r2d;
    in_imm      = imm;
    in_use_imm  = ui;
    in_alu_ctrl = c;
    in_rd_addr  = rd;
    in_rd_we    = (rd != 5'd0);
  endtask

  logic [31:0] fwd_exp;

  initial begin
    // Reset state
    step();
    step();
    chk_en = 1'b1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_bus_A", out_bus_A, 32'd0);
    check("rst_bus_B", out_bus_B, 32'd0);
    check("rst_ctrl", {27'd0, out_alu_ctrl}, 32'd0);
    check("rst_rd", {26'd0, out_rd_addr, out_rd_we}, 32'd0);
    rst = 1'b0;
    step();

    // Streaming with out_ready=1
    out_ready = 1'b1;
    put(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'b00000, 5'd4);
    step();
    check("addu_valid", {31'd0, out_valid}, 32'd1);
    check("addu_A", out_bus_A, 32'd5);
    check("addu_B", out_bus_B, 32'd7);
    check("addu_ctrl", {27'd0, out_alu_ctrl}, 32'd0);
    check("addu_rd", {27'd0, out_rd_addr}, 32'd4);
    put(5'd1, 32'd10, 5'd2, 32'd99, 32'd3, 1'b1, 5'b00001, 5'd5);
    step();
    check("subu_A", out_bus_A, 32'd3);
    check("subu_B", out_bus_B, 32'd10);
    put(5'd1, 32'd1, 5'd2, 32'h25, 32'd0, 1'b0, 5'b00110, 5'd6);
    step();
    check("sll_A", out_bus_A, 32'd5);
    check("sll_B", out_bus_B, 32'd1);
    put(5'd1, 32'h8000_0000, 5'd2, 32'h21, 32'd0, 1'b0, 5'b01000, 5'd7);
    step();
    check("sra_A", out_bus_A, 32'h8000_0000);
    check("sra_B", out_bus_B, 32'd1);
    put(5'd1, 32'h1234, 5'd2, 32'h55, 32'd0, 1'b0, 5'b11111, 5'd0);
    step();
    check("undef_A", out_bus_A, 32'h1234);
    check("undef_B", out_bus_B, 32'h55);
    check("undef_ctrl", {27'd0, out_alu_ctrl}, 32'd31);
    in_valid = 1'b0;
    step();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Back-pressure: three back-to-back with out_ready=0
    out_ready = 1'b0;
    put(5'd1, 32'h111, 5'd2, 32'h1, 32'd0, 1'b0, 5'b00000, 5'd1);
    step();
    put(5'd1, 32'h222, 5'd2, 32'h2, 32'd0, 1'b0, 5'b00000, 5'd2);
    step();
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    put(5'd1, 32'h333, 5'd2, 32'h3, 32'd0, 1'b0, 5'b00000, 5'd3);
    step();
    check("full_hold_A", out_bus_A, 32'h111);
    check("full_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    check("drain1_A", out_bus_A, 32'h222);
    check("drain1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("drain2_A", out_bus_A, 32'h333);
    in_valid = 1'b0;
    step();
    check("drain3_valid", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with an incoming instruction
    out_ready = 1'b0;
    put(5'd1, 32'h444, 5'd2, 32'h4, 32'd0, 1'b0, 5'b00000, 5'd1);
    step();
    put(5'd1, 32'h555, 5'd2, 32'h5, 32'd0, 1'b0, 5'b00000, 5'd2);
    step();
    put(5'd1, 32'h666, 5'd2, 32'h6, 32'd0, 1'b0, 5'b00000, 5'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("flush_stay_empty", {31'd0, out_valid}, 32'd0);

    // Forwarding
    out_ready = 1'b1;
`ifdef FWD_EN
    fwd_exp = 32'hDEAD_BEEF;
`else
    fwd_exp = 32'd0;
`endif
    put(5'd3, 32'd0, 5'd9, 32'h11, 32'd0, 1'b0, 5'b00000, 5'd8);
    fwd_we = 1'b1; fwd_addr = 5'd3; fwd_data = 32'hDEAD_BEEF;
    step();
    check("fwd_A", out_bus_A, fwd_exp);
    check("fwd_B", out_bus_B, 32'h11);
    put(5'd0, 32'd0, 5'd9, 32'h11, 32'd0, 1'b0, 5'b00000, 5'd8);
    fwd_addr = 5'd0;
    step();
    check("fwd_r0_A", out_bus_A, 32'd0);
    fwd_we = 1'b0;
    in_valid = 1'b0;
    step();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    put(5'd1, 32'h777, 5'd2, 32'h7, 32'd0, 1'b0, 5'b00000, 5'd1);
    step();
    put(5'd1, 32'h888, 5'd2, 32'h8, 32'd0, 1'b0, 5'b00000, 5'd2);
    step();
    in_valid = 1'b0;
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
